// File: rtl/oam_dma_if.sv
// CPU-side inputs and system-bus-side outputs of the OAM DMA arbiter.
// The slave view belongs to the DMA engine; the master view belongs to whatever drives the CPU side.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_dout;
    logic [7:0]  bus_din;
    logic        halt;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_dout;
    logic        done;

    modport slave (
        input  cpu_addr, cpu_rw, cpu_dout, bus_din,
        output halt, bus_addr, bus_rw, bus_dout, done
    );

    modport master (
        output cpu_addr, cpu_rw, cpu_dout, bus_din,
        input  halt, bus_addr, bus_rw, bus_dout, done
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to REG_ADDR halts the CPU and copies COUNT bytes
// from page V to DEST_ADDR in get/put pairs. When idle, the CPU bus passes straight through.
module oam_dma #(
    parameter logic [15:0] REG_ADDR  = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004,
    parameter int          COUNT     = 256
) (
    input  logic      clk,
    input  logic      rst_n,
    oam_dma_if.slave  dma_if
);
    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

    typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  latch_q, latch_d;
    logic        parity_q;
    logic        done_q, done_d;

    logic        halt_w;
    logic [15:0] addr_w;
    logic        rw_w;
    logic [7:0]  dout_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            page_q   <= 8'd0;
            latch_q  <= 8'd0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            page_q   <= page_d;
            latch_q  <= latch_d;
            parity_q <= ~parity_q;
            done_q   <= done_d;
        end
    end

    // Outputs are decoded from the current state only, so an async reset drops halt immediately.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        latch_d = latch_q;
        done_d  = 1'b0;
        halt_w  = 1'b1;
        addr_w  = dma_if.cpu_addr;
        rw_w    = 1'b1;
        dout_w  = dma_if.cpu_dout;
        unique case (state_q)
            S_IDLE: begin
                halt_w = 1'b0;
                rw_w   = dma_if.cpu_rw;
                if (!dma_if.cpu_rw && dma_if.cpu_addr == REG_ADDR) begin
                    page_d  = dma_if.cpu_dout;
                    idx_d   = 8'd0;
                    state_d = S_HALT;
                end
            end
            // Reads must land on get (parity=0) cycles; ALIGN burns one cycle when they would not.
            S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                addr_w  = {page_q, idx_q};
                latch_d = dma_if.bus_din;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_w = DEST_ADDR;
                rw_w   = 1'b0;
                dout_w = latch_q;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 8'd0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dma_if.halt     = halt_w;
    assign dma_if.bus_addr = addr_w;
    assign dma_if.bus_rw   = rw_w;
    assign dma_if.bus_dout = dout_w;
    assign dma_if.done     = done_q;
endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: reset pass-through, idle pass-through vectors, full transfers on both
// parities, page $FF, and an asynchronous reset abort followed by a fresh transfer.
module tb_oam_dma;
    localparam logic [15:0] REG_ADDR  = 16'h4014;
    localparam logic [15:0] DEST_ADDR = 16'h2004;
    localparam logic [15:0] PARK_ADDR = 16'h8123;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tb_par;
    int   errors = 0;
    int   checks = 0;

    logic [7:0]  exp_wr[$];
    logic [15:0] exp_rd[$];

    oam_dma_if dif();

    oam_dma #(.REG_ADDR(REG_ADDR), .DEST_ADDR(DEST_ADDR), .COUNT(256)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dma_if (dif.slave)
    );

    always #5 clk = ~clk;

    // Memory model: mem[$ppxx] = xx ^ 8'h5A for every page.
    always_comb dif.bus_din = dif.bus_addr[7:0] ^ 8'h5A;

    // Reference parity: toggles every clock since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_par <= 1'b0;
        else        tb_par <= ~tb_par;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_pass(input string name);
        check({name, "_addr"}, 32'(dif.bus_addr), 32'(dif.cpu_addr));
        check({name, "_rw"},   32'(dif.bus_rw),   32'(dif.cpu_rw));
        check({name, "_dout"}, 32'(dif.bus_dout), 32'(dif.cpu_dout));
    endtask

    task automatic run_dma(input logic [7:0] pg, input logic par, input int abort_at);
        int halt_cnt = 0, dummy = 0, wr = 0, guard = 0;
        bit fin = 0, aborted = 0;
        logic [15:0] last_rd = 16'h0;
        @(negedge clk);
        while (tb_par != par) @(negedge clk);
        dif.cpu_addr = REG_ADDR; dif.cpu_rw = 1'b0; dif.cpu_dout = pg;
        for (int i = 0; i < 256; i++) begin
            exp_wr.push_back(8'(i) ^ 8'h5A);
            exp_rd.push_back({pg, 8'(i)});
        end
        #1;
        check_pass("trigger_pass");
        check("trigger_halt", 32'(dif.halt), 0);
        @(posedge clk); #1;
        dif.cpu_addr = PARK_ADDR; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h77;
        @(negedge clk);
        check("halt_latency", 32'(dif.halt), 1);
        while (!fin && guard < 1200) begin
            guard++;
            if (dif.halt) begin
                halt_cnt++;
                check("done_during_halt", 32'(dif.done), 0);
                check("addr_nonzero", 32'(dif.bus_addr != 16'h0), 1);
                if (!dif.bus_rw) begin
                    wr++;
                    check("put_addr", 32'(dif.bus_addr), 32'(DEST_ADDR));
                    if (exp_wr.size() == 0) check("put_extra", 32'(wr), 256);
                    else check("put_data", 32'(dif.bus_dout), 32'(exp_wr.pop_front()));
                    if (wr == abort_at) begin
                        @(posedge clk); #2;
                        rst_n = 1'b0;
                        #1;
                        check("abort_halt", 32'(dif.halt), 0);
                        check_pass("abort_pass");
                        repeat (3) begin
                            @(negedge clk);
                            check("abort_no_put", 32'(dif.bus_rw), 1);
                            check("abort_done", 32'(dif.done), 0);
                        end
                        rst_n = 1'b1;
                        exp_wr.delete();
                        exp_rd.delete();
                        aborted = 1;
                        fin = 1;
                    end
                end else if (dif.bus_addr == PARK_ADDR) begin
                    dummy++;
                end else begin
                    last_rd = dif.bus_addr;
                    if (exp_rd.size() == 0) check("get_extra", 32'(dif.bus_addr), 0);
                    else check("get_addr", 32'(dif.bus_addr), 32'(exp_rd.pop_front()));
                end
            end else begin
                fin = 1;
                check("done_pulse", 32'(dif.done), 1);
            end
            if (!fin) @(negedge clk);
        end
        if (!fin) check("transfer_timeout", 0, 1);
        if (!aborted) begin
            check("halt_cycles", 32'(halt_cnt), 32'(513 + int'(par)));
            check("dummy_reads", 32'(dummy), 32'(1 + int'(par)));
            check("put_count", 32'(wr), 256);
            check("last_get", 32'(last_rd), 32'({pg, 8'hFF}));
            check("puts_left", 32'(exp_wr.size()), 0);
            check("gets_left", 32'(exp_rd.size()), 0);
            @(negedge clk);
            check("done_single", 32'(dif.done), 0);
            check("halt_after", 32'(dif.halt), 0);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic [15:0] exp_a;
        logic        exp_rw;
        logic [7:0]  exp_d;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h4014, 1'b1, 8'h02, 16'h4014, 1'b1, 8'h02, 1'b0};
        vecs[1] = '{16'h4015, 1'b0, 8'h33, 16'h4015, 1'b0, 8'h33, 1'b0};
        vecs[2] = '{16'h4013, 1'b0, 8'h02, 16'h4013, 1'b0, 8'h02, 1'b0};
        vecs[3] = '{16'h2004, 1'b1, 8'hC3, 16'h2004, 1'b1, 8'hC3, 1'b0};
        vecs[4] = '{16'h0000, 1'b0, 8'hFF, 16'h0000, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{16'hFFFF, 1'b1, 8'h00, 16'hFFFF, 1'b1, 8'h00, 1'b0};

        dif.cpu_addr = 16'h0; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dif.cpu_addr = 16'($urandom);
            dif.cpu_rw   = 1'($urandom);
            dif.cpu_dout = 8'($urandom);
            if (i == 3) begin dif.cpu_addr = REG_ADDR; dif.cpu_rw = 1'b0; end
            #1;
            check("rst_halt", 32'(dif.halt), 0);
            check("rst_done", 32'(dif.done), 0);
            check_pass("rst_pass");
        end
        @(negedge clk);
        dif.cpu_addr = 16'h0; dif.cpu_rw = 1'b1; dif.cpu_dout = 8'h0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dif.cpu_addr = vecs[i].a; dif.cpu_rw = vecs[i].rw; dif.cpu_dout = vecs[i].d;
            @(posedge clk); #1;
            check("vec_addr", 32'(dif.bus_addr), 32'(vecs[i].exp_a));
            check("vec_rw",   32'(dif.bus_rw),   32'(vecs[i].exp_rw));
            check("vec_dout", 32'(dif.bus_dout), 32'(vecs[i].exp_d));
            check("vec_halt", 32'(dif.halt),     32'(vecs[i].exp_halt));
        end
        @(negedge clk);
        dif.cpu_addr = 16'h0; dif.cpu_rw = 1'b1;

        run_dma(8'h02, 1'b0, 0);
        run_dma(8'h02, 1'b1, 0);
        run_dma(8'hFF, 1'b0, 0);
        run_dma(8'h02, 1'b0, 100);
        run_dma(8'h03, 1'b0, 0);
        run_dma(8'h03, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
